// File: rtl/hilo_unit_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: HILOop command
// encodings and FSM state encodings. The divide state exists only when
// HILO_DIV_EN is defined.
package hilo_unit_pkg;

    // HILOop encodings; 3'd0 and 3'd7 mean "no operation".
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
`ifdef HILO_DIV_EN
        ST_DIV  = 2'd2,
`endif
        ST_FIX  = 2'd3
    } hilo_state_e;

endpackage

// File: rtl/hilo_div.sv
// Restoring divider core: one quotient bit per cycle on unsigned magnitudes.
// A start pulse loads the operands; WIDTH steps follow. 'done' is high during
// the cycle whose closing edge performs the final step, so quotient/remainder
// are valid from the following cycle. Divisor 0 naturally yields an all-ones
// quotient and remainder equal to the dividend.
module hilo_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic             run_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] quot_reg;
    logic [WIDTH-1:0] rem_reg;
    logic [WIDTH-1:0] dvsr_reg;

    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   diff;
    logic             ge;

    // One restoring step: shift in the next dividend bit and trial-subtract.
    always_comb begin
        rem_shift = {rem_reg, quot_reg[WIDTH-1]};
        diff      = rem_shift - {1'b0, dvsr_reg};
        ge        = (rem_shift >= {1'b0, dvsr_reg});
    end

    assign done      = run_reg && (cnt_reg == CW'(WIDTH - 1));
    assign quotient  = quot_reg;
    assign remainder = rem_reg;

    // Operand load on start, then WIDTH iterations; the dividend shifts out of
    // quot_reg as quotient bits shift in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_reg  <= 1'b0;
            cnt_reg  <= '0;
            quot_reg <= '0;
            rem_reg  <= '0;
            dvsr_reg <= '0;
        end else if (start) begin
            run_reg  <= 1'b1;
            cnt_reg  <= '0;
            quot_reg <= dividend;
            rem_reg  <= '0;
            dvsr_reg <= divisor;
        end else if (run_reg) begin
            rem_reg  <= ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
            quot_reg <= {quot_reg[WIDTH-2:0], ge};
            cnt_reg  <= cnt_reg + CW'(1);
            if (done) begin
                run_reg <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner for the multi-cycle MIPS core. Handles MTHI/MTLO in
// one edge and runs MULT/MULTU (shift-add) and, when HILO_DIV_EN is defined,
// DIV/DIVU (restoring, via hilo_div) over WIDTH iterations plus one sign-fix
// and commit cycle. Without HILO_DIV_EN, DIV/DIVU are no-ops.
module hilo_unit
    import hilo_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       HILOop,
    input  logic             HILOwe,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [WIDTH-1:0]   ZERO  = '0;
    localparam logic [2*WIDTH-1:0] ZERO2 = '0;

    hilo_state_e        state_reg, state_next;
    logic [CW-1:0]      cnt_reg, cnt_next;
    logic [WIDTH-1:0]   mcand_reg, mcand_next;
    logic [2*WIDTH-1:0] acc_reg, acc_next;
    logic               neg_q_reg, neg_q_next;
    logic [WIDTH-1:0]   hi_reg, hi_next;
    logic [WIDTH-1:0]   lo_reg, lo_next;
    logic               busy_reg, busy_next;

    logic               is_signed_op;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] acc_step;
    logic [2*WIDTH-1:0] prod_fix;

`ifdef HILO_DIV_EN
    logic               neg_r_reg, neg_r_next;
    logic               is_div_reg, is_div_next;
    logic               div_start;
    logic [WIDTH-1:0]   div_q, div_r;
    logic               div_done;

    hilo_div #(.WIDTH(WIDTH)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (div_q),
        .remainder (div_r),
        .done      (div_done)
    );
`endif

    // Operand magnitudes (two's-complement negate, so the most negative value
    // maps to itself) and the shift-add multiply step.
    always_comb begin
        is_signed_op = (HILOop == OP_MULT) || (HILOop == OP_DIV);
        a_mag        = (is_signed_op && a[WIDTH-1]) ? (ZERO - a) : a;
        b_mag        = (is_signed_op && b[WIDTH-1]) ? (ZERO - b) : b;
        mul_sum      = {1'b0, acc_reg[2*WIDTH-1:WIDTH]}
                     + (acc_reg[0] ? {1'b0, mcand_reg} : {1'b0, ZERO});
        acc_step     = {mul_sum, acc_reg[WIDTH-1:1]};
        prod_fix     = neg_q_reg ? (ZERO2 - acc_reg) : acc_reg;
    end

    // Next-state and datapath control; everything holds unless a state acts.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mcand_next = mcand_reg;
        acc_next   = acc_reg;
        neg_q_next = neg_q_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
`ifdef HILO_DIV_EN
        neg_r_next  = neg_r_reg;
        is_div_next = is_div_reg;
        div_start   = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (HILOwe) begin
                    case (HILOop)
                        OP_MTHI: hi_next = a;
                        OP_MTLO: lo_next = a;
                        OP_MULT, OP_MULTU: begin
                            mcand_next = a_mag;
                            acc_next   = {ZERO, b_mag};
                            neg_q_next = is_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            cnt_next   = '0;
                            state_next = ST_MUL;
`ifdef HILO_DIV_EN
                            is_div_next = 1'b0;
`endif
                        end
`ifdef HILO_DIV_EN
                        OP_DIV, OP_DIVU: begin
                            neg_q_next  = is_signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r_next  = is_signed_op && a[WIDTH-1];
                            is_div_next = 1'b1;
                            div_start   = 1'b1;
                            state_next  = ST_DIV;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            ST_MUL: begin
                acc_next = acc_step;
                cnt_next = cnt_reg + CW'(1);
                if (cnt_reg == CW'(WIDTH - 1)) begin
                    state_next = ST_FIX;
                end
            end
`ifdef HILO_DIV_EN
            ST_DIV: begin
                if (div_done) begin
                    state_next = ST_FIX;
                end
            end
`endif
            ST_FIX: begin
`ifdef HILO_DIV_EN
                if (is_div_reg) begin
                    hi_next = neg_r_reg ? (ZERO - div_r) : div_r;
                    lo_next = neg_q_reg ? (ZERO - div_q) : div_q;
                end else begin
                    hi_next = prod_fix[2*WIDTH-1:WIDTH];
                    lo_next = prod_fix[WIDTH-1:0];
                end
`else
                hi_next = prod_fix[2*WIDTH-1:WIDTH];
                lo_next = prod_fix[WIDTH-1:0];
`endif
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign busy_next = (state_next != ST_IDLE);

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            mcand_reg <= '0;
            acc_reg   <= '0;
            neg_q_reg <= 1'b0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            busy_reg  <= 1'b0;
`ifdef HILO_DIV_EN
            neg_r_reg  <= 1'b0;
            is_div_reg <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mcand_reg <= mcand_next;
            acc_reg   <= acc_next;
            neg_q_reg <= neg_q_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            busy_reg  <= busy_next;
`ifdef HILO_DIV_EN
            neg_r_reg  <= neg_r_next;
            is_div_reg <= is_div_next;
`endif
        end
    end

    assign hi   = hi_reg;
    assign lo   = lo_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit: directed boundary cases followed by
// random commands, compared against an arithmetic model of HI/LO.
module tb_hilo_unit;

`ifdef HILO_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [2:0]  HILOop;
    logic        HILOwe;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;

    int tests;
    int errors;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    hilo_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .HILOop (HILOop),
        .HILOwe (HILOwe),
        .a      (a),
        .b      (b),
        .hi     (hi),
        .lo     (lo),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: new HI/LO after a command from the arithmetic definition.
    task automatic model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                         output bit iter);
        logic [63:0] p;
        longint      sx, sy;
        logic [31:0] am, bm, qm, rm;
        bit          sa, sb;
        iter = 1'b0;
        case (op)
            3'd5: exp_hi = x;
            3'd6: exp_lo = x;
            3'd1: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                p  = sx * sy;
                {exp_hi, exp_lo} = p;
                iter = 1'b1;
            end
            3'd2: begin
                p = {32'd0, x} * {32'd0, y};
                {exp_hi, exp_lo} = p;
                iter = 1'b1;
            end
            3'd3, 3'd4: begin
                if (DIV_EN) begin
                    sa = (op == 3'd3) && x[31];
                    sb = (op == 3'd3) && y[31];
                    am = sa ? 32'd0 - x : x;
                    bm = sb ? 32'd0 - y : y;
                    qm = (bm == 32'd0) ? 32'hFFFF_FFFF : am / bm;
                    rm = (bm == 32'd0) ? am : am % bm;
                    exp_lo = (sa ^ sb) ? 32'd0 - qm : qm;
                    exp_hi = sa ? 32'd0 - rm : rm;
                    iter = 1'b1;
                end
            end
            default: ;
        endcase
    endtask

    // Present one command for exactly one sampling edge.
    task automatic drive_cmd(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        HILOwe = 1'b1;
        HILOop = op;
        a      = x;
        b      = y;
        @(posedge clk);
        #1;
        HILOwe = 1'b0;
        HILOop = 3'd0;
        a      = $urandom;
        b      = $urandom;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y);
        bit          iter;
        logic [31:0] old_hi, old_lo;
        int          n;
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(op, x, y, iter);
        drive_cmd(op, x, y);
        if (iter) begin
            check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
            check({tag, "_hi_hold"}, hi, old_hi);
            check({tag, "_lo_hold"}, lo, old_lo);
            n = 0;
            while (busy === 1'b1 && n < 100) begin
                n++;
                @(posedge clk);
                #1;
            end
            check({tag, "_busy_cycles"}, n, 32'd33);
        end else begin
            check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        end
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        $display("[TB] %s op=%0d a=%h b=%h -> hi=%h lo=%h", tag, op, x, y, hi, lo);
    endtask

    initial begin
        bit          iter;
        int          n;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        tests  = 0;
        errors = 0;
        rst    = 1'b1;
        HILOwe = 1'b0;
        HILOop = 3'd0;
        a      = '0;
        b      = '0;
        exp_hi = '0;
        exp_lo = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_hi", hi, 32'd0);
        check("reset_lo", lo, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases from the operation rules.
        run_op("mthi", 3'd5, 32'h1234_5678, 32'h0);
        run_op("mtlo", 3'd6, 32'hCAFE_F00D, 32'h0);
        run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
        check("multu_max_lo_const", lo, 32'h0000_0001);
        run_op("mult_neg", 3'd1, 32'hFFFF_FFFD, 32'd7);
        check("mult_neg_lo_const", lo, 32'hFFFF_FFEB);
        run_op("mult_minint", 3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_zero", 3'd4, 32'd100, 32'd0);
        run_op("div_wrap", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_zero_neg", 3'd3, 32'hFFFF_FFF0, 32'd0);
        run_op("nop0", 3'd0, 32'h5555_5555, 32'h1);
        run_op("nop7", 3'd7, 32'h5555_5555, 32'h1);

        // Random commands, including undefined codes and zero divisors.
        for (int i = 0; i < 24; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9));
            run_op($sformatf("rnd%0d", i), rop, ra, rb);
        end

        // MTLO while busy must be ignored.
        ra = $urandom;
        rb = $urandom;
        model(3'd1, ra, rb, iter);
        drive_cmd(3'd1, ra, rb);
        repeat (3) @(posedge clk);
        drive_cmd(3'd6, 32'hDEAD_BEEF, 32'h0);
        check("mtlo_busy_still", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check("mtlo_ign_done", {31'd0, busy}, 32'd0);
        check("mtlo_ign_hi", hi, exp_hi);
        check("mtlo_ign_lo", lo, exp_lo);
        $display("[TB] mult+mtlo a=%h b=%h -> hi=%h lo=%h", ra, rb, hi, lo);

        // Reset in the middle of a multiply discards it immediately.
        drive_cmd(3'd2, 32'hFFFF_FFFF, 32'h1234_5678);
        repeat (9) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'd0);
        check("midrst_lo", lo, 32'd0);
        exp_hi = '0;
        exp_lo = '0;
        $display("[TB] reset during multu -> hi=%h lo=%h busy=%0d", hi, lo, busy);
        @(negedge clk);
        rst = 1'b0;
        run_op("mthi_after_rst", 3'd5, 32'hA5A5_0F0F, 32'h0);
        run_op("mult_after_rst", 3'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
